// File: rtl/matmul_host_sequencer.sv
// Host-side sequencer for the 16x16 matmul top: streams A/B rows into BRAM,
// runs the multiply, then returns C rows through a credit-guarded output FIFO.
module matmul_host_sequencer #(
   parameter int A_WORDS      = 16,
   parameter int B_WORDS      = 16,
   parameter int C_WORDS      = 8,
   parameter int WR_ADDR_LEAD = 2,
   parameter int RD_LATENCY   = 6,
   parameter int FIFO_DEPTH   = 8
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         go,
   output logic         busy,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] out_data,
   output logic [127:0] data_pi,
   output logic [6:0]   addr_pi,
   output logic         we_a,
   output logic         we_b,
   output logic         we_c,
   output logic         enable_writing_to_mem,
   output logic         enable_reading_from_mem,
   output logic         start_mat_mul_0,
   input  logic         done_mat_mul,
   input  logic [127:0] data_from_out_mat
);

   localparam int AW  = 7;
   localparam int FCW = (WR_ADDR_LEAD > 1) ? $clog2(WR_ADDR_LEAD) : 1;
   localparam int PW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW  = $clog2(FIFO_DEPTH + 1);
   localparam int IW  = $clog2(RD_LATENCY + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD_A,
      S_LOAD_B,
      S_LOAD_FLUSH,
      S_COMPUTE,
      S_READ,
      S_DRAIN
   } state_t;

   state_t                  state_q, state_d;
   logic [AW-1:0]           wc_q, wc_d;
   logic [AW-1:0]           rc_q, rc_d;
   logic [AW-1:0]           addr_q, addr_d;
   logic [FCW-1:0]          fc_q, fc_d;

   logic [127:0]            dl_data_q [WR_ADDR_LEAD];
   logic [127:0]            dl_data_d [WR_ADDR_LEAD];
   logic [WR_ADDR_LEAD-1:0] dl_vld_q, dl_vld_d;
   logic [WR_ADDR_LEAD-1:0] dl_isb_q, dl_isb_d;

   logic [RD_LATENCY-1:0]   infl_q, infl_d;
   logic [IW-1:0]           infl_cnt;
   logic                    infl_tail_busy;
   logic                    credit_ok;

   logic [127:0]            fifo_mem_q [FIFO_DEPTH];
   logic [PW-1:0]           wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]           rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]           cnt_q, cnt_d;
   logic                    fifo_push, fifo_pop;

   logic                    wr_push, wr_isb, rd_issue;

   // ---------------- main sequencer ----------------
   always_comb begin
      state_d                 = state_q;
      wc_d                    = wc_q;
      rc_d                    = rc_q;
      fc_d                    = fc_q;
      busy                    = 1'b1;
      in_ready                = 1'b0;
      enable_writing_to_mem   = 1'b0;
      enable_reading_from_mem = 1'b0;
      start_mat_mul_0         = 1'b0;
      we_c                    = 1'b0;
      addr_pi                 = '0;
      wr_push                 = 1'b0;
      wr_isb                  = 1'b0;
      rd_issue                = 1'b0;

      case (state_q)
         S_IDLE: begin
            busy = 1'b0;
            if (go) begin
               state_d = S_LOAD_A;
               wc_d    = '0;
            end
         end
         S_LOAD_A, S_LOAD_B: begin
            enable_writing_to_mem = 1'b1;
            in_ready              = 1'b1;
            addr_pi               = addr_q;
            if (in_valid) begin
               addr_pi = wc_q;
               wr_push = 1'b1;
               wr_isb  = (state_q == S_LOAD_B);
               if (state_q == S_LOAD_A) begin
                  if (wc_q == AW'(A_WORDS - 1)) begin
                     wc_d    = '0;
                     state_d = S_LOAD_B;
                  end else begin
                     wc_d = wc_q + AW'(1);
                  end
               end else if (wc_q == AW'(B_WORDS - 1)) begin
                  wc_d    = '0;
                  fc_d    = '0;
                  state_d = S_LOAD_FLUSH;
               end else begin
                  wc_d = wc_q + AW'(1);
               end
            end
         end
         S_LOAD_FLUSH: begin
            // Hold the write port until the last delayed word has been written.
            enable_writing_to_mem = 1'b1;
            addr_pi               = addr_q;
            if (fc_q == FCW'(WR_ADDR_LEAD - 1)) begin
               state_d = S_COMPUTE;
            end else begin
               fc_d = fc_q + FCW'(1);
            end
         end
         S_COMPUTE: begin
            start_mat_mul_0 = 1'b1;
            we_c            = 1'b1;
            if (done_mat_mul) begin
               state_d = S_READ;
               rc_d    = '0;
            end
         end
         S_READ: begin
            enable_reading_from_mem = 1'b1;
            addr_pi                 = addr_q;
            if (credit_ok) begin
               rd_issue = 1'b1;
               addr_pi  = rc_q;
               if (rc_q == AW'(C_WORDS - 1)) begin
                  state_d = S_DRAIN;
               end else begin
                  rc_d = rc_q + AW'(1);
               end
            end
         end
         S_DRAIN: begin
            enable_reading_from_mem = 1'b1;
            addr_pi                 = addr_q;
            if (!infl_tail_busy && cnt_d == '0) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      addr_d = addr_pi;
   end

   // ---------------- write delay line ----------------
   always_comb begin
      dl_data_d[0] = wr_push ? in_data : '0;
      dl_vld_d[0]  = wr_push;
      dl_isb_d[0]  = wr_isb;
      for (int i = 1; i < WR_ADDR_LEAD; i++) begin
         dl_data_d[i] = dl_data_q[i-1];
         dl_vld_d[i]  = dl_vld_q[i-1];
         dl_isb_d[i]  = dl_isb_q[i-1];
      end
   end

   assign we_a    = enable_writing_to_mem & dl_vld_q[WR_ADDR_LEAD-1] & ~dl_isb_q[WR_ADDR_LEAD-1];
   assign we_b    = enable_writing_to_mem & dl_vld_q[WR_ADDR_LEAD-1] &  dl_isb_q[WR_ADDR_LEAD-1];
   assign data_pi = (enable_writing_to_mem && dl_vld_q[WR_ADDR_LEAD-1]) ?
                    dl_data_q[WR_ADDR_LEAD-1] : '0;

   // ---------------- read credit tracking ----------------
   always_comb begin
      infl_cnt       = '0;
      infl_tail_busy = 1'b0;
      for (int i = 0; i < RD_LATENCY; i++) begin
         infl_cnt = infl_cnt + IW'(infl_q[i]);
         if (i < RD_LATENCY - 1) begin
            infl_tail_busy = infl_tail_busy | infl_q[i];
         end
      end
      // A pop in this cycle is not credited back yet; that keeps the rule conservative.
      credit_ok = (int'(infl_cnt) + int'(cnt_q)) < FIFO_DEPTH;
   end

   always_comb begin
      infl_d[0] = rd_issue;
      for (int i = 1; i < RD_LATENCY; i++) begin
         infl_d[i] = infl_q[i-1];
      end
   end

   // ---------------- output FIFO ----------------
   always_comb begin
      fifo_push = infl_q[RD_LATENCY-1];
      fifo_pop  = (cnt_q != '0) && out_ready;
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      cnt_d     = cnt_q;
      if (fifo_push) begin
         wr_ptr_d = (wr_ptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
      end
      if (fifo_pop) begin
         rd_ptr_d = (rd_ptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
      end
      if (fifo_push && !fifo_pop) begin
         cnt_d = cnt_q + CW'(1);
      end else if (!fifo_push && fifo_pop) begin
         cnt_d = cnt_q - CW'(1);
      end
   end

   assign out_valid = (cnt_q != '0);
   assign out_data  = out_valid ? fifo_mem_q[rd_ptr_q] : '0;

   // ---------------- registers ----------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= S_IDLE;
         wc_q     <= '0;
         rc_q     <= '0;
         addr_q   <= '0;
         fc_q     <= '0;
         dl_vld_q <= '0;
         dl_isb_q <= '0;
         infl_q   <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         for (int i = 0; i < WR_ADDR_LEAD; i++) begin
            dl_data_q[i] <= '0;
         end
      end else begin
         state_q  <= state_d;
         wc_q     <= wc_d;
         rc_q     <= rc_d;
         addr_q   <= addr_d;
         fc_q     <= fc_d;
         dl_vld_q <= dl_vld_d;
         dl_isb_q <= dl_isb_d;
         infl_q   <= infl_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
         for (int i = 0; i < WR_ADDR_LEAD; i++) begin
            dl_data_q[i] <= dl_data_d[i];
         end
      end
   end

   // Storage needs no reset: an empty FIFO never exposes it and out_data is gated.
   always_ff @(posedge clk) begin
      if (fifo_push) begin
         fifo_mem_q[wr_ptr_q] <= data_from_out_mat;
      end
   end

endmodule

// File: tb/tb_matmul_host_sequencer.sv
// Directed/randomized bench for matmul_host_sequencer with a memory-level
// reference model of the A/B/C BRAMs and an ordered C-row scoreboard.
module tb_matmul_host_sequencer;

   localparam int A_WORDS      = 16;
   localparam int B_WORDS      = 16;
   localparam int WR_ADDR_LEAD = 2;
   localparam int RD_LATENCY   = 6;

   logic         clk;
   logic         reset_n;
   logic         go;
   logic         busy;
   logic         in_valid;
   logic         in_ready;
   logic [127:0] in_data;
   logic         out_valid;
   logic         out_ready;
   logic [127:0] out_data;
   logic [127:0] data_pi;
   logic [6:0]   addr_pi;
   logic         we_a, we_b, we_c;
   logic         enable_writing_to_mem, enable_reading_from_mem;
   logic         start_mat_mul_0;
   logic         done_mat_mul;
   logic [127:0] data_from_out_mat;

   matmul_host_sequencer dut (
      .clk                     (clk),
      .reset_n                 (reset_n),
      .go                      (go),
      .busy                    (busy),
      .in_valid                (in_valid),
      .in_ready                (in_ready),
      .in_data                 (in_data),
      .out_valid               (out_valid),
      .out_ready               (out_ready),
      .out_data                (out_data),
      .data_pi                 (data_pi),
      .addr_pi                 (addr_pi),
      .we_a                    (we_a),
      .we_b                    (we_b),
      .we_c                    (we_c),
      .enable_writing_to_mem   (enable_writing_to_mem),
      .enable_reading_from_mem (enable_reading_from_mem),
      .start_mat_mul_0         (start_mat_mul_0),
      .done_mat_mul            (done_mat_mul),
      .data_from_out_mat       (data_from_out_mat)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   typedef struct {
      int           due;
      logic [127:0] data;
      bit           isb;
   } wr_t;

   wr_t          wq [$];
   logic [127:0] exp_c [$];
   logic [127:0] words [32];
   logic [127:0] a_mem [128];
   logic [127:0] b_mem [128];
   logic [127:0] c_mem [8];
   logic [6:0]   ah [7];
   int           hs_n     = 0;
   int           last_hs  = 0;
   int           first_ov = -1;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic rst_check(input string tag);
      chk({tag, "_ctl"}, {busy, in_ready, out_valid, addr_pi, we_a, we_b, we_c,
                          enable_writing_to_mem, enable_reading_from_mem, start_mat_mul_0}, '0);
      chk({tag, "_data_pi"}, data_pi, '0);
      chk({tag, "_out_data"}, out_data, '0);
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Memory model and per-cycle protocol observer, sampled mid-cycle.
   always @(negedge clk) begin
      for (int i = 6; i > 0; i--) ah[i] = ah[i-1];
      ah[0] = addr_pi;
      data_from_out_mat = c_mem[ah[RD_LATENCY][2:0]];
      if (!reset_n) begin
         wq.delete();
         hs_n = 0;
      end else begin
         if (go && !busy) hs_n = 0;
         if (we_a) a_mem[ah[WR_ADDR_LEAD]] = data_pi;
         if (we_b) b_mem[ah[WR_ADDR_LEAD]] = data_pi;
         if (wq.size() > 0 && wq[0].due == cyc) begin
            chk("we_a", we_a, !wq[0].isb);
            chk("we_b", we_b, wq[0].isb);
            chk("data_pi", data_pi, wq[0].data);
            void'(wq.pop_front());
         end else begin
            chk("no_we", {we_a, we_b}, 2'b00);
         end
         if (in_valid && in_ready) begin
            chk("hs_addr", addr_pi, (hs_n < A_WORDS) ? hs_n : hs_n - A_WORDS);
            wq.push_back('{cyc + WR_ADDR_LEAD, in_data, (hs_n >= A_WORDS)});
            last_hs = cyc;
            hs_n++;
         end
         if (out_valid && first_ov < 0) first_ov = cyc;
         if (out_valid && out_ready) begin
            if (exp_c.size() == 0) chk("extra_row", 1, 0);
            else chk("out_data", out_data, exp_c.pop_front());
         end
      end
   end

   task automatic do_run(input bit gapped, input bit bp, input bit fixed);
      int n, guard, s, r;
      for (int i = 0; i < 32; i++)
         words[i] = fixed ? 128'(i + 1) : {$urandom(), $urandom(), $urandom(), $urandom()};
      for (int i = 0; i < 128; i++) begin
         a_mem[i] = 'x;
         b_mem[i] = 'x;
      end
      exp_c.delete();
      for (int i = 0; i < 8; i++) begin
         c_mem[i] = fixed ? 128'(i + 'hA0) : {$urandom(), $urandom(), $urandom(), $urandom()};
         exp_c.push_back(c_mem[i]);
      end
      first_ov  = -1;
      out_ready = !bp;
      go = 1'b1;
      tick();
      go = 1'b0;

      n = 0;
      guard = 0;
      while (n < 32 && guard < 1000) begin
         in_valid = gapped ? 1'($urandom_range(0, 1)) : 1'b1;
         in_data  = words[n];
         @(negedge clk);
         if (in_valid && in_ready) n++;
         tick();
         guard++;
      end
      in_valid = 1'b0;
      chk("load_count", n, 32);

      guard = 0;
      do begin
         @(negedge clk);
         guard++;
      end while (!start_mat_mul_0 && guard < 50);
      s = cyc;
      chk("start_rise", s, last_hs + WR_ADDR_LEAD + 1);
      for (int i = 0; i < A_WORDS; i++) chk("mem_a", a_mem[i], words[i]);
      for (int i = 0; i < B_WORDS; i++) chk("mem_b", b_mem[i], words[A_WORDS + i]);

      for (int i = 0; i < 40; i++) begin
         if (i > 0) @(negedge clk);
         chk("compute_hold", {start_mat_mul_0, we_c, busy, enable_reading_from_mem}, 4'b1110);
      end
      tick();
      done_mat_mul = 1'b1;
      go = 1'b1;
      @(negedge clk);
      chk("compute_last", {start_mat_mul_0, we_c}, 2'b11);
      tick();
      done_mat_mul = 1'b0;
      go = 1'b0;
      @(negedge clk);
      chk("read_entry", {start_mat_mul_0, we_c, enable_reading_from_mem, busy}, 4'b0011);
      r = cyc;

      if (bp) begin
         repeat (20) @(negedge clk);
         chk("bp_valid", {out_valid, busy, enable_reading_from_mem}, 3'b111);
         chk("bp_held_rows", exp_c.size(), 8);
      end
      guard = 0;
      while (busy && guard < 500) begin
         tick();
         if (bp) out_ready = 1'($urandom_range(0, 1));
         @(negedge clk);
         guard++;
      end
      chk("drain_done", busy, 0);
      chk("rows_left", exp_c.size(), 0);
      if (!bp) begin
         chk("first_out", first_ov, r + RD_LATENCY + 1);
         chk("busy_fall", cyc, r + RD_LATENCY + 1 + 8);
      end
      tick();
      out_ready = 1'b0;
   endtask

   initial begin
      reset_n      = 1'b0;
      go           = 1'b0;
      in_valid     = 1'b0;
      in_data      = '0;
      out_ready    = 1'b0;
      done_mat_mul = 1'b0;
      for (int i = 0; i < 8; i++) c_mem[i] = '0;
      repeat (2) @(posedge clk);
      #1;
      rst_check("reset");
      reset_n = 1'b1;
      tick();

      do_run(1'b0, 1'b0, 1'b1);
      do_run(1'b1, 1'b1, 1'b0);

      go = 1'b1;
      tick();
      go = 1'b0;
      in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         in_data = 128'(i + 'h55);
         tick();
      end
      reset_n = 1'b0;
      #1;
      rst_check("rst_mid");
      tick();
      in_valid = 1'b0;
      reset_n  = 1'b1;
      @(negedge clk);
      chk("idle_after_rst", {busy, in_ready, out_valid}, 3'b000);
      tick();
      done_mat_mul = 1'b1;
      @(negedge clk);
      chk("done_in_idle", {busy, start_mat_mul_0, we_c}, 3'b000);
      tick();
      done_mat_mul = 1'b0;

      do_run(1'b1, 1'b0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
